ntr_host: RTL and testbench

//  NTR bus initiator: plays the console side against our cartridge responder. Serialises a
//  64-bit command onto the 8-bit NTR bus, releases the bus, then clocks in a programmable number
//  of response bytes. Each response byte is presented on a valid/ready stream.

---
 rtl/ntr_host_pkg.sv | 9 +
 rtl/ntr_clk_gen.sv | 32 +++
 rtl/ntr_host.sv | 105 ++++++++++
 tb/tb_ntr_host.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ntr_host_pkg.sv
// ntr_host_pkg: shared constants, FSM states and responder opcodes for the NTR host
package ntr_host_pkg;
  localparam int CMD_BYTES = 8;
  typedef enum logic [2:0] {IDLE, SEL, CMD, GAP, READ, END} state_t;
  localparam logic [7:0] OP_LED    = 8'hFF;
  localparam logic [7:0] OP_SERIAL = 8'h22;
  localparam logic [7:0] OP_CHIPID = 8'h90;
  localparam logic [7:0] OP_DUMMY  = 8'h9F;
endpackage

// File: rtl/ntr_clk_gen.sv
// ntr_clk_gen: half-period divider producing ntr_clk_o plus tick/rise/fall strobes
module ntr_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic stall,
  input  logic park,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic ntr_clk_o
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt;
  logic term;
  assign term = cnt == CW'(CLK_DIV - 1);
  assign tick = en && term && !stall;
  // park keeps counting half-periods while the bus clock stays high
  assign rise = tick && !park && !ntr_clk_o;
  assign fall = tick && !park && ntr_clk_o;
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt       <= '0;
      ntr_clk_o <= 1'b1;
    end else begin
      if (!(term && stall)) cnt <= term ? '0 : cnt + 1'b1;
      if (rise || fall) ntr_clk_o <= ~ntr_clk_o;
    end
  end
endmodule

// File: rtl/ntr_host.sv
// ntr_host: NTR bus initiator sending a 64-bit command and streaming back read_len response bytes
module ntr_host
  import ntr_host_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int GAP_CLKS = 2,
  parameter int LEN_W    = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [63:0]      cmd,
  input  logic [LEN_W-1:0] read_len,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             ntr_clk_o,
  output logic             ntr_cs1_o,
  output logic             ntr_data_oe,
  output logic [7:0]       ntr_data_o,
  input  logic [7:0]       ntr_data_i
);
  state_t st;
  logic [63:0] cmd_q;
  logic [LEN_W-1:0] rcnt;
  logic [2:0] bcnt;
  logic [7:0] gcnt;
  logic hp, tick, rise, fall, stall;
  // an unaccepted byte freezes the bus clock high before it can fall
  assign stall = st == READ && rd_valid && !rd_ready && ntr_clk_o;
  ntr_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk (
    .clk(clk), .reset(reset), .en(st != IDLE), .stall(stall), .park(st == END),
    .tick(tick), .rise(rise), .fall(fall), .ntr_clk_o(ntr_clk_o)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      ntr_cs1_o   <= 1'b1;
      ntr_data_oe <= 1'b0;
      ntr_data_o  <= '0;
      cmd_q       <= '0;
      rcnt        <= '0;
      bcnt        <= '0;
      gcnt        <= '0;
      hp          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (rd_ready) rd_valid <= 1'b0;
      case (st)
        IDLE: if (start) begin
          cmd_q       <= cmd;
          rcnt        <= read_len;
          busy        <= 1'b1;
          ntr_cs1_o   <= 1'b0;
          ntr_data_oe <= 1'b1;
          ntr_data_o  <= cmd[7:0];
          bcnt        <= '0;
          hp          <= 1'b0;
          st          <= SEL;
        end
        SEL: if (fall) st <= CMD;
        CMD: begin
          if (fall) ntr_data_o <= cmd_q[{bcnt, 3'b000} +: 8];
          if (rise) begin
            bcnt <= bcnt + 1'b1;
            if (bcnt == 3'(CMD_BYTES - 1)) begin
              ntr_data_oe <= 1'b0;
              gcnt        <= '0;
              ntr_cs1_o   <= rcnt == '0;
              st          <= rcnt == '0 ? END : GAP;
            end
          end
        end
        GAP: if (rise) begin
          gcnt <= gcnt + 1'b1;
          if (gcnt == 8'(GAP_CLKS - 1)) st <= READ;
        end
        READ: if (rise) begin
          rd_data  <= ntr_data_i;
          rd_valid <= 1'b1;
          rcnt     <= rcnt - 1'b1;
          if (rcnt == LEN_W'(1)) begin
            ntr_cs1_o <= 1'b1;
            st        <= END;
          end
        end
        END: begin
          if (tick) hp <= 1'b1;
          if ((hp || tick) && (!rd_valid || rd_ready)) begin
            busy <= 1'b0;
            done <= 1'b1;
            st   <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ntr_host.sv
// tb_ntr_host: randomized transactions against a behavioural cartridge responder and stream scoreboard
module tb_ntr_host;
  localparam int DIV = 4;
  localparam int GAP = 2;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, rd_valid, rd_ready = 1'b1;
  logic busy, done, ntr_clk_o, ntr_cs1_o, ntr_data_oe;
  logic [63:0] cmd = '0;
  logic [11:0] read_len = '0;
  logic [7:0] rd_data, ntr_data_o, ntr_data_i = 8'h5A;
  int n_tests = 0, n_fail = 0;
  int cyc = 0, rises = 0, nrise = 0, dones = 0, nvalid = 0, viol = 0;
  int hold = 0, stall_bad = 0, rmode = 0, cyc_cs1 = 0, cyc_done = 0;
  logic [7:0] bus[$], rx[$];
  logic [63:0] rcmd = '0;
  logic [7:0] rled = '0, eled = '0;

  ntr_host #(.CLK_DIV(DIV), .GAP_CLKS(GAP), .LEN_W(12)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd), .read_len(read_len),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .ntr_clk_o(ntr_clk_o), .ntr_cs1_o(ntr_cs1_o), .ntr_data_oe(ntr_data_oe),
    .ntr_data_o(ntr_data_o), .ntr_data_i(ntr_data_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // cartridge reply: chip id, LED state, or a command-derived pattern, sent LSB first
  function automatic logic [7:0] resp(input logic [63:0] c, input int k, input logic [7:0] led);
    logic [31:0] w;
    w = c[7:0] == 8'h90 ? 32'h807F01E0 : c[7:0] == 8'hFF ? {24'h0, led} :
        {c[15:8], c[23:16] ^ 8'(k), 8'(k * 29 + 7), c[31:24] ^ 8'(k)};
    return w[8 * (k % 4) +: 8];
  endfunction

  // responder and consumer, evaluated once per cycle away from the active edge
  initial begin
    logic pv, pr, pclk, poe, pcs1;
    logic [7:0] pd, pdo;
    pv = 0; pr = 0; pclk = 1; poe = 0; pcs1 = 1; pd = 0; pdo = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pv && pr) rx.push_back(pd);
      if (!pclk && ntr_clk_o) begin
        nrise++;
        rises++;
        if (poe && bus.size() < 8) begin
          bus.push_back(pdo);
          if (bus.size() == 8) begin
            for (int i = 0; i < 8; i++) rcmd[8 * i +: 8] = bus[i];
            if (rcmd[7:0] == 8'hFF) rled = rcmd[63:56];
          end
        end
      end
      if (ntr_cs1_o) nrise = 0;
      if (!pcs1 && ntr_cs1_o) cyc_cs1 = cyc;
      if (done) begin dones++; cyc_done = cyc; end
      if (ntr_data_oe && ntr_cs1_o) viol++;
      if (rd_valid) nvalid++;
      if (rmode == 1) rd_ready = 1'($urandom_range(0, 1));
      else if (rmode == 2 && rx.size() == 1 && hold < 20) begin
        hold++;
        rd_ready = 1'b0;
        if (rd_valid && !ntr_clk_o) stall_bad++;
      end else rd_ready = 1'b1;
      ntr_data_i = nrise >= 8 + GAP ? resp(rcmd, nrise - 8 - GAP, rled) : 8'h5A;
      pv = rd_valid; pr = rd_ready; pd = rd_data;
      pclk = ntr_clk_o; poe = ntr_data_oe; pdo = ntr_data_o; pcs1 = ntr_cs1_o;
    end
  end

  task automatic run_txn(input logic [63:0] c, input int len, input int mode, input bit poke);
    int d0, t;
    @(negedge clk);
    bus.delete(); rx.delete();
    rises = 0; nvalid = 0; viol = 0; hold = 0; stall_bad = 0; rmode = mode; d0 = dones;
    if (c[7:0] == 8'hFF) eled = c[63:56];
    cmd = c; read_len = 12'(len); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    if (poke) begin
      repeat (30) @(negedge clk);
      cmd = ~c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    t = 0;
    while (dones == d0 && t < 20000) begin @(negedge clk); t++; end
    chk("done_timeout", 64'(dones != d0), 1);
    repeat (6) @(negedge clk);
    chk("bus_count", bus.size(), 8);
    for (int i = 0; i < bus.size(); i++) chk("bus_byte", bus[i], 64'(c[8 * i +: 8]));
    chk("rd_count", rx.size(), len);
    for (int k = 0; k < rx.size(); k++) chk("rd_byte", rx[k], resp(c, k, eled));
    chk("rise_edges", rises, 8 + (len > 0 ? GAP + len : 0));
    chk("done_pulses", dones - d0, 1);
    chk("oe_with_cs_high", viol, 0);
    chk("busy_end", busy, 0);
    if (len == 0) chk("no_valid", nvalid, 0);
    if (mode == 0) chk("done_latency", cyc_done - cyc_cs1, DIV);
    if (mode == 2) begin
      chk("stall_clk_high", stall_bad, 0);
      chk("stall_window", hold, 20);
    end
  endtask

  initial begin
    int t, d0;
    logic [63:0] c;
    logic [7:0] ops[5];
    ops = '{8'h90, 8'hFF, 8'h22, 8'h9F, 8'h00};
    repeat (4) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_clk", ntr_clk_o, 1);
    chk("rst_cs1", ntr_cs1_o, 1);
    chk("rst_oe", ntr_data_oe, 0);
    chk("rst_dout", ntr_data_o, 0);
    reset = 1'b0;
    run_txn(64'h90, 4, 0, 0);
    run_txn(64'h0100_0000_0000_00FF, 4, 0, 0);
    run_txn({$urandom, $urandom}, 0, 0, 0);
    run_txn(64'h90, 4, 2, 0);
    run_txn({32'h1234_5678, $urandom, 8'h9F}, 6, 0, 1);
    // reset while the second response byte is in flight
    @(negedge clk);
    rmode = 0; cmd = 64'h90; read_len = 12'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (rises < 8 + GAP + 1 && t < 2000) begin @(negedge clk); t++; end
    chk("reach_read", 64'(rises >= 8 + GAP + 1), 1);
    rises = 0;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_cs1", ntr_cs1_o, 1);
    chk("mid_rst_clk", ntr_clk_o, 1);
    chk("mid_rst_oe", ntr_data_oe, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", rd_valid, 0);
    d0 = dones;
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("mid_rst_no_done", dones - d0, 0);
    run_txn(64'h90, 4, 0, 0);
    for (int n = 0; n < 8; n++) begin
      c = {$urandom, $urandom};
      c[7:0] = ops[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) c[7:0] = 8'($urandom);
      run_txn(c, $urandom_range(0, 12), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
